// File: rtl/ramp_adc_ctrl.sv
// Single-slope ADC controller: steps a PWM-DAC ramp, waits for filter settling, samples the comparator.
// Optional build macro RAMP_ADC_AVG_EN: four back-to-back ramps per start, averaged result.
module ramp_adc_ctrl #(
    parameter int WIDTH          = 8,
    parameter int SETTLE_PERIODS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmp_in,
    output logic             pwm_out,
    output logic [WIDTH-1:0] code_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overrange
);
    localparam int PW = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;
    localparam logic [WIDTH-1:0] MAX_CODE = '1;
    localparam logic [PW-1:0]    LAST_PERIOD = PW'(SETTLE_PERIODS - 1);

    typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] pwm_cnt;
    logic [PW-1:0]    period_cnt;
    logic             cmp_s1;
    logic             cmp_s;
    logic [WIDTH-1:0] pwm_cnt_inc;
    logic [WIDTH-1:0] code_inc;
    logic             sample_point;
    logic             ramp_end;

    assign pwm_cnt_inc  = pwm_cnt + 1'b1;
    assign code_inc     = code_out + 1'b1;
    assign sample_point = (pwm_cnt == MAX_CODE) && (period_cnt == LAST_PERIOD);
    // A ramp ends on a comparator trip or when full scale is sampled without one.
    assign ramp_end     = cmp_s || (code_out == MAX_CODE);

`ifdef RAMP_ADC_AVG_EN
    logic [WIDTH+1:0] acc;
    logic [1:0]       ramp_idx;
    logic             ovr_any;
    logic [WIDTH+1:0] sum_next;

    assign sum_next = acc + {2'b00, code_out};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pwm_out    <= 1'b0;
            code_out   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            overrange  <= 1'b0;
            pwm_cnt    <= '0;
            period_cnt <= '0;
            cmp_s1     <= 1'b0;
            cmp_s      <= 1'b0;
`ifdef RAMP_ADC_AVG_EN
            acc        <= '0;
            ramp_idx   <= '0;
            ovr_any    <= 1'b0;
`endif
        end else begin
            cmp_s1 <= cmp_in;
            cmp_s  <= cmp_s1;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    pwm_out    <= 1'b0;
                    code_out   <= '0;
                    pwm_cnt    <= '0;
                    period_cnt <= '0;
                    busy       <= 1'b0;
`ifdef RAMP_ADC_AVG_EN
                    acc        <= '0;
                    ramp_idx   <= '0;
                    ovr_any    <= 1'b0;
`endif
                    if (start) begin
                        state <= RAMP;
                        busy  <= 1'b1;
                    end
                end
                RAMP: begin
                    if (sample_point) begin
                        pwm_cnt    <= '0;
                        period_cnt <= '0;
                        if (ramp_end) begin
`ifdef RAMP_ADC_AVG_EN
                            if (ramp_idx == 2'd3) begin
                                result    <= sum_next[WIDTH+1:2];
                                overrange <= ovr_any | ~cmp_s;
                                state     <= DONE;
                                done      <= 1'b1;
                                busy      <= 1'b0;
                                pwm_out   <= 1'b0;
                            end else begin
                                // Next ramp starts immediately from code 0.
                                acc      <= sum_next;
                                ovr_any  <= ovr_any | ~cmp_s;
                                ramp_idx <= ramp_idx + 2'd1;
                                code_out <= '0;
                                pwm_out  <= 1'b0;
                            end
`else
                            result    <= code_out;
                            overrange <= ~cmp_s;
                            state     <= DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            pwm_out   <= 1'b0;
`endif
                        end else begin
                            code_out <= code_inc;
                            pwm_out  <= 1'b1;
                        end
                    end else begin
                        // pwm_out is computed from the next counter value so it lines up with pwm_cnt.
                        pwm_cnt <= pwm_cnt_inc;
                        pwm_out <= (pwm_cnt_inc < code_out);
                        if (pwm_cnt == MAX_CODE) begin
                            period_cnt <= period_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    code_out <= '0;
                    pwm_out  <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
